// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package serial_add_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/serial_fa_slice.sv
// One-bit full adder: two half adders plus an OR of their carries.
module serial_fa_slice (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum_c,
    output logic carry_c
);

    logic ha0_sum_c;
    logic ha0_carry_c;
    logic ha1_carry_c;

    // First half adder on the operand bits, second folds in the carry.
    assign ha0_sum_c   = a ^ b;
    assign ha0_carry_c = a & b;
    assign sum_c       = ha0_sum_c ^ ci;
    assign ha1_carry_c = ha0_sum_c & ci;
    assign carry_c     = ha0_carry_c | ha1_carry_c;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: feeds one full-adder slice LSB first and
// publishes the registered sum/carry with a one-cycle done pulse.
// Optional build macro SERIAL_ADD_OVERFLOW_EN adds a registered signed
// overflow flag (overflow_out).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             ready_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
`ifdef SERIAL_ADD_OVERFLOW_EN
    output logic             overflow_out,
`endif
    output logic             carry_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t             state_q;
    state_t             state_d;
    logic               accept_c;
    logic               last_c;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   s_r;
    logic               carry_r;
    logic               fa_sum_c;
    logic               fa_carry_c;

    // Single adder slice operating on the current LSBs and the carry register.
    serial_fa_slice u_slice (
        .a       (a_r[0]),
        .b       (b_r[0]),
        .ci      (carry_r),
        .sum_c   (fa_sum_c),
        .carry_c (fa_carry_c)
    );

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus accept/last-bit strobes.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        last_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    accept_c = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    last_c  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status flags registered from the next state so they track state_q exactly.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ready_out <= 1'b1;
            busy_out  <= 1'b0;
            done_out  <= 1'b0;
        end else begin
            ready_out <= (state_d == IDLE);
            busy_out  <= (state_d == SHIFT);
            done_out  <= (state_d == DONE);
        end
    end

    // Operand capture and one-bit-per-cycle shift datapath.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            a_r     <= '0;
            b_r     <= '0;
            s_r     <= '0;
            carry_r <= 1'b0;
            cnt_q   <= '0;
        end else if (accept_c) begin
            a_r     <= a_in;
            b_r     <= b_in;
            s_r     <= '0;
            carry_r <= c_in;
            cnt_q   <= '0;
        end else if (state_q == SHIFT) begin
            a_r     <= a_r >> 1;
            b_r     <= b_r >> 1;
            s_r     <= {fa_sum_c, s_r[WIDTH-1:1]};
            carry_r <= fa_carry_c;
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    // Result registers load only on the edge that processes the final bit.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sum_out      <= '0;
            carry_out    <= 1'b0;
`ifdef SERIAL_ADD_OVERFLOW_EN
            overflow_out <= 1'b0;
`endif
        end else if (last_c) begin
            sum_out      <= {fa_sum_c, s_r[WIDTH-1:1]};
            carry_out    <= fa_carry_c;
`ifdef SERIAL_ADD_OVERFLOW_EN
            // carry_r here is the carry into the MSB.
            overflow_out <= carry_r ^ fa_carry_c;
`endif
        end
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Sequencer that drives one one-bit full-adder slice in bit-serial fashion to add two WIDTH-bit operands plus a carry-in. It sits between a requesting block and the adder datapath. It accepts operands on a start/ready handshake, feeds the slice one bit pair per clock (LSB first) through a registered carry, and presents the registered sum and carry-out with a one-cycle done pulse.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 2..64.
- clk_in  input  1  clock; all state updates on rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- start_in  input  1  request; accepted only when ready_out=1.
- a_in  input  WIDTH  operand A; sampled on accept.
- b_in  input  WIDTH  operand B; sampled on accept.
- c_in  input  1  carry-in; sampled on accept.
- ready_out  output  1  high in IDLE only.
- busy_out  output  1  high in SHIFT only.
- done_out  output  1  one-cycle pulse in DONE.
- sum_out  output  WIDTH  registered result; held until next DONE.
- carry_out  output  1  registered carry-out; held until next DONE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE→SHIFT on start_in=1. Capture a_in/b_in into shift registers A_r/B_r and c_in into carry_r; clear bit counter cnt.
  - SHIFT: each cycle the slice computes s = A_r[0]^B_r[0]^carry_r and the new carry from the same bits. s shifts into the MSB of result register S_r (shift right); A_r/B_r shift right; carry_r takes the new carry; cnt increments.
  - SHIFT→DONE when the bit with cnt=WIDTH-1 is processed. On that edge, load sum_out with the final S_r contents including the last bit and carry_out with the final carry.
  - DONE→IDLE unconditionally after one cycle.
- start_in outside IDLE is ignored; no queuing. Operands are not re-sampled.
- Reset values:
  - All outputs 0 except ready_out=1.
  - State IDLE; cnt, A_r, B_r, S_r and carry_r all 0.
- Reset asserted mid-operation aborts immediately. sum_out/carry_out return to 0 and there is no done pulse.
- Arithmetic is unsigned modulo 2^WIDTH, with carry_out as bit WIDTH of a_in+b_in+c_in.
- cnt width is clog2(WIDTH). It is never compared beyond WIDTH-1 and has no wrap dependence.

## Timing
- Accept edge E0 (start_in=1, ready_out=1). SHIFT occupies edges E1..E(WIDTH). done_out is high in the cycle following E(WIDTH), and ready_out returns to 1 after E(WIDTH+1).
- Latency from accept to done_out is WIDTH+1 cycles. Throughput is one add per WIDTH+2 cycles.
- sum_out/carry_out change only on the DONE-entry edge. They are stable during SHIFT, so they show the previous result.
- done_out, ready_out and busy_out are decoded from registered state: glitch-free, no combinational path from inputs.

## Configuration
- SERIAL_ADD_OVERFLOW_EN defined:
  - Adds port overflow_out (output, 1 bit) = signed two's-complement overflow, i.e. carry into the MSB XOR carry out of the MSB.
  - The carry into the MSB is taken from carry_r before the final SHIFT edge.
  - Loaded on the DONE-entry edge alongside sum_out. Reset value 0.
- Undefined: no overflow_out port and no extra register; all other behaviour identical.

## Structure
- Package serial_add_pkg holds the state enum (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the default width constant.
- One sub-module, serial_fa_slice: a combinational one-bit full adder built from two half adders plus an OR of their carries. It is instantiated once; all sequencing lives in serial_add_ctrl.

## Test plan
- WIDTH=8: a=8'h0F, b=8'h01, c=0 → done_out exactly 9 cycles after accept; sum_out=8'h10, carry_out=0.
- a=8'hFF, b=8'h01, c=0 → sum_out=8'h00, carry_out=1. a=0, b=0, c=1 → sum_out=8'h01, carry_out=0.
- With SERIAL_ADD_OVERFLOW_EN: a=8'h7F, b=8'h01 → overflow_out=1. a=8'hFF, b=8'h01 → overflow_out=0, carry_out=1.
- Pulse start_in with new operands during SHIFT → ignored; the result matches the first operands and exactly one done pulse occurs.
- Assert rst_n_in low at the 4th SHIFT cycle → the next cycle shows ready_out=1, busy_out=0, sum_out=0, and no done_out. A fresh add then completes correctly.
- Back-to-back: hold start_in=1 continuously → an accept occurs every 10 cycles, each result correct; random operands are checked against a+b+c.
